// File: rtl/axil_reg_if_rd_q.sv
// AXI-Lite read channel to register-interface bridge with a queued response FIFO,
// address-window decode and a wait-extendable timeout. Macro: AXIL_REG_RD_TIMEOUT_ERR_EN.
module axil_reg_if_rd_q #(
   parameter int DATA_WIDTH     = 32,
   parameter int ADDR_WIDTH     = 32,
   parameter int REG_ADDR_WIDTH = 16,
   parameter int TIMEOUT        = 4,
   parameter int RESP_DEPTH     = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [ADDR_WIDTH-1:0] s_axil_araddr,
   input  logic [2:0]            s_axil_arprot,
   input  logic                  s_axil_arvalid,
   output logic                  s_axil_arready,
   output logic [DATA_WIDTH-1:0] s_axil_rdata,
   output logic [1:0]            s_axil_rresp,
   output logic                  s_axil_rvalid,
   input  logic                  s_axil_rready,
   output logic [ADDR_WIDTH-1:0] reg_rd_addr,
   output logic                  reg_rd_en,
   input  logic [DATA_WIDTH-1:0] reg_rd_data,
   input  logic                  reg_rd_wait,
   input  logic                  reg_rd_ack
);

   localparam int TMR_W = $clog2(TIMEOUT + 1);
   localparam int PTR_W = $clog2(RESP_DEPTH);
   localparam int CNT_W = $clog2(RESP_DEPTH + 1);

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;
   localparam logic [1:0] RESP_DECERR = 2'b11;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACCESS = 2'd1,
      ST_DECERR = 2'd2
   } state_t;

   state_t                state_q, state_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [TMR_W-1:0]      tmr_q, tmr_d;
   logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]      count_q, count_d;
   logic [DATA_WIDTH-1:0] data_mem_q [RESP_DEPTH];
   logic [DATA_WIDTH-1:0] data_mem_d [RESP_DEPTH];
   logic [1:0]            resp_mem_q [RESP_DEPTH];
   logic [1:0]            resp_mem_d [RESP_DEPTH];

   logic                  ar_hs;
   logic                  out_of_range;
   logic                  push;
   logic                  pop;
   logic [DATA_WIDTH-1:0] push_data;
   logic [1:0]            push_resp;
   logic                  unused_arprot;

   assign unused_arprot = ^s_axil_arprot;

   // AR is only taken when a FIFO slot is free, so the single in-flight access always has room.
   assign s_axil_arready = (state_q == ST_IDLE) && (count_q < CNT_W'(RESP_DEPTH));
   assign ar_hs          = s_axil_arvalid && s_axil_arready;
   assign out_of_range   = (s_axil_araddr >> REG_ADDR_WIDTH) != '0;

   assign reg_rd_en      = (state_q == ST_ACCESS);
   assign reg_rd_addr    = addr_q;

   assign s_axil_rvalid  = (count_q != '0);
   assign s_axil_rdata   = s_axil_rvalid ? data_mem_q[rd_ptr_q] : '0;
   assign s_axil_rresp   = s_axil_rvalid ? resp_mem_q[rd_ptr_q] : '0;
   assign pop            = s_axil_rvalid && s_axil_rready;

   // Access FSM: next state, address capture, timeout counter and response push.
   always_comb begin
      state_d   = state_q;
      addr_d    = addr_q;
      tmr_d     = tmr_q;
      push      = 1'b0;
      push_data = '0;
      push_resp = RESP_OKAY;
      case (state_q)
         ST_IDLE: begin
            if (ar_hs) begin
               addr_d  = s_axil_araddr;
               tmr_d   = TMR_W'(TIMEOUT - 1);
               state_d = out_of_range ? ST_DECERR : ST_ACCESS;
            end
         end
         ST_ACCESS: begin
            if (reg_rd_ack) begin
               push      = 1'b1;
               push_data = reg_rd_data;
               push_resp = RESP_OKAY;
               state_d   = ST_IDLE;
            end else if ((tmr_q == '0) && !reg_rd_wait) begin
               push = 1'b1;
`ifdef AXIL_REG_RD_TIMEOUT_ERR_EN
               push_data = '0;
               push_resp = RESP_SLVERR;
`else
               push_data = reg_rd_data;
               push_resp = RESP_OKAY;
`endif
               state_d = ST_IDLE;
            end else if (!reg_rd_wait) begin
               tmr_d = tmr_q - TMR_W'(1);
            end
         end
         ST_DECERR: begin
            push      = 1'b1;
            push_data = '0;
            push_resp = RESP_DECERR;
            state_d   = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // Response FIFO bookkeeping; pointers wrap naturally since the depth is a power of two.
   always_comb begin
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      count_d    = count_q;
      data_mem_d = data_mem_q;
      resp_mem_d = resp_mem_q;
      if (push) begin
         data_mem_d[wr_ptr_q] = push_data;
         resp_mem_d[wr_ptr_q] = push_resp;
         wr_ptr_d             = wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      case ({push, pop})
         2'b10:   count_d = count_q + CNT_W'(1);
         2'b01:   count_d = count_q - CNT_W'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= ST_IDLE;
         addr_q   <= '0;
         tmr_q    <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         state_q  <= state_d;
         addr_q   <= addr_d;
         tmr_q    <= tmr_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage needs no reset: entries are only visible once count_q covers them.
   always_ff @(posedge clk) begin
      data_mem_q <= data_mem_d;
      resp_mem_q <= resp_mem_d;
   end

endmodule

// File: tb/tb_axil_reg_if_rd_q.sv
// Directed bench for axil_reg_if_rd_q: reset, single read, backpressure, timeout,
// wait extension, ack/timeout priority, decode error and reset mid-access.
module tb_axil_reg_if_rd_q;

   localparam int DW = 32;
   localparam int AW = 32;
   localparam int TO = 4;

   logic          clk;
   logic          rst;
   logic [AW-1:0] s_axil_araddr;
   logic [2:0]    s_axil_arprot;
   logic          s_axil_arvalid;
   logic          s_axil_arready;
   logic [DW-1:0] s_axil_rdata;
   logic [1:0]    s_axil_rresp;
   logic          s_axil_rvalid;
   logic          s_axil_rready;
   logic [AW-1:0] reg_rd_addr;
   logic          reg_rd_en;
   logic [DW-1:0] reg_rd_data;
   logic          reg_rd_wait;
   logic          reg_rd_ack;

   int errors = 0;
   int checks = 0;

   axil_reg_if_rd_q #(
      .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .REG_ADDR_WIDTH(16), .TIMEOUT(TO), .RESP_DEPTH(4)
   ) dut (
      .clk(clk), .rst(rst),
      .s_axil_araddr(s_axil_araddr), .s_axil_arprot(s_axil_arprot),
      .s_axil_arvalid(s_axil_arvalid), .s_axil_arready(s_axil_arready),
      .s_axil_rdata(s_axil_rdata), .s_axil_rresp(s_axil_rresp),
      .s_axil_rvalid(s_axil_rvalid), .s_axil_rready(s_axil_rready),
      .reg_rd_addr(reg_rd_addr), .reg_rd_en(reg_rd_en), .reg_rd_data(reg_rd_data),
      .reg_rd_wait(reg_rd_wait), .reg_rd_ack(reg_rd_ack)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   logic [DW-1:0] to_data;
   logic [1:0]    to_resp;

   initial begin
`ifdef AXIL_REG_RD_TIMEOUT_ERR_EN
      to_data = 32'h0;
      to_resp = 2'b10;
`else
      to_data = 32'h1234_5678;
      to_resp = 2'b00;
`endif
      rst = 1'b1;
      s_axil_araddr = '0;
      s_axil_arprot = 3'b000;
      s_axil_arvalid = 1'b0;
      s_axil_rready = 1'b0;
      reg_rd_data = '0;
      reg_rd_wait = 1'b0;
      reg_rd_ack = 1'b0;
      tick();
      tick();
      rst = 1'b0;

      // Reset values
      check("rst_arready", s_axil_arready, 1);
      check("rst_rvalid", s_axil_rvalid, 0);
      check("rst_rdata", s_axil_rdata, 0);
      check("rst_rresp", s_axil_rresp, 0);
      check("rst_en", reg_rd_en, 0);
      check("rst_addr", reg_rd_addr, 0);

      // Single read, ack in first enable cycle
      s_axil_rready = 1'b1;
      s_axil_arvalid = 1'b1;
      s_axil_araddr = 32'h0000_0010;
      check("single_arready", s_axil_arready, 1);
      tick();
      s_axil_arvalid = 1'b0;
      check("single_en", reg_rd_en, 1);
      check("single_addr", reg_rd_addr, 32'h10);
      check("single_rvalid_n1", s_axil_rvalid, 0);
      reg_rd_ack = 1'b1;
      reg_rd_data = 32'hDEAD_BEEF;
      tick();
      reg_rd_ack = 1'b0;
      check("single_rvalid", s_axil_rvalid, 1);
      check("single_rdata", s_axil_rdata, 32'hDEAD_BEEF);
      check("single_rresp", s_axil_rresp, 0);
      check("single_en_off", reg_rd_en, 0);
      tick();
      check("single_drained", s_axil_rvalid, 0);

      // Backpressure: four immediate-ack reads fill the FIFO
      s_axil_rready = 1'b0;
      for (int i = 0; i < 4; i++) begin
         s_axil_arvalid = 1'b1;
         s_axil_araddr = 32'h100 + 32'(4 * i);
         check("bp_arready", s_axil_arready, 1);
         tick();
         s_axil_arvalid = 1'b0;
         reg_rd_ack = 1'b1;
         reg_rd_data = 32'hA000_0000 + 32'(i);
         tick();
         reg_rd_ack = 1'b0;
      end
      s_axil_arvalid = 1'b1;
      s_axil_araddr = 32'h200;
      for (int i = 0; i < 3; i++) begin
         check("bp_full_arready", s_axil_arready, 0);
         check("bp_full_en", reg_rd_en, 0);
         tick();
      end
      s_axil_rready = 1'b1;
      check("bp_pop_cycle_arready", s_axil_arready, 0);
      check("bp_resp0", s_axil_rdata, 32'hA000_0000);
      tick();
      check("bp_arready_after_pop", s_axil_arready, 1);
      check("bp_resp1", s_axil_rdata, 32'hA000_0001);
      tick();
      s_axil_arvalid = 1'b0;
      check("bp_5th_en", reg_rd_en, 1);
      check("bp_5th_addr", reg_rd_addr, 32'h200);
      check("bp_resp2", s_axil_rdata, 32'hA000_0002);
      reg_rd_ack = 1'b1;
      reg_rd_data = 32'h0000_00B5;
      tick();
      reg_rd_ack = 1'b0;
      check("bp_resp3", s_axil_rdata, 32'hA000_0003);
      tick();
      check("bp_resp4", s_axil_rdata, 32'h0000_00B5);
      check("bp_resp4_resp", s_axil_rresp, 0);
      tick();
      check("bp_drained", s_axil_rvalid, 0);

      // Timeout with no ack and no wait
      reg_rd_data = 32'h1234_5678;
      s_axil_arvalid = 1'b1;
      s_axil_araddr = 32'h20;
      tick();
      s_axil_arvalid = 1'b0;
      for (int i = 0; i < TO; i++) begin
         check("to_en", reg_rd_en, 1);
         check("to_rvalid_low", s_axil_rvalid, 0);
         tick();
      end
      check("to_en_off", reg_rd_en, 0);
      check("to_rvalid", s_axil_rvalid, 1);
      check("to_rresp", s_axil_rresp, to_resp);
      check("to_rdata", s_axil_rdata, to_data);
      tick();

      // Wait held for ten cycles, then ack
      s_axil_arvalid = 1'b1;
      s_axil_araddr = 32'h24;
      tick();
      s_axil_arvalid = 1'b0;
      reg_rd_wait = 1'b1;
      for (int i = 0; i < 10; i++) begin
         check("wait_en", reg_rd_en, 1);
         check("wait_rvalid_low", s_axil_rvalid, 0);
         tick();
      end
      reg_rd_wait = 1'b0;
      reg_rd_ack = 1'b1;
      reg_rd_data = 32'h0000_CAFE;
      check("wait_en_11th", reg_rd_en, 1);
      tick();
      reg_rd_ack = 1'b0;
      check("wait_en_off", reg_rd_en, 0);
      check("wait_rvalid", s_axil_rvalid, 1);
      check("wait_rdata", s_axil_rdata, 32'h0000_CAFE);
      check("wait_rresp", s_axil_rresp, 0);
      tick();

      // Ack in the same cycle the counter reaches zero wins over timeout
      s_axil_arvalid = 1'b1;
      s_axil_araddr = 32'h28;
      tick();
      s_axil_arvalid = 1'b0;
      for (int i = 0; i < TO - 1; i++) tick();
      check("prio_en", reg_rd_en, 1);
      reg_rd_ack = 1'b1;
      reg_rd_data = 32'h0000_0077;
      tick();
      reg_rd_ack = 1'b0;
      check("prio_rvalid", s_axil_rvalid, 1);
      check("prio_rdata", s_axil_rdata, 32'h77);
      check("prio_rresp", s_axil_rresp, 0);
      tick();

      // Decode error
      s_axil_arvalid = 1'b1;
      s_axil_araddr = 32'h0001_0000;
      check("dec_arready", s_axil_arready, 1);
      tick();
      s_axil_arvalid = 1'b0;
      check("dec_en_n1", reg_rd_en, 0);
      check("dec_rvalid_n1", s_axil_rvalid, 0);
      tick();
      check("dec_en_n2", reg_rd_en, 0);
      check("dec_rvalid", s_axil_rvalid, 1);
      check("dec_rresp", s_axil_rresp, 2'b11);
      check("dec_rdata", s_axil_rdata, 0);
      tick();

      // Reset during an access with two queued responses
      s_axil_rready = 1'b0;
      for (int i = 0; i < 2; i++) begin
         s_axil_arvalid = 1'b1;
         s_axil_araddr = 32'h300 + 32'(4 * i);
         tick();
         s_axil_arvalid = 1'b0;
         reg_rd_ack = 1'b1;
         reg_rd_data = 32'hBB00_0000 + 32'(i);
         tick();
         reg_rd_ack = 1'b0;
      end
      s_axil_arvalid = 1'b1;
      s_axil_araddr = 32'h308;
      tick();
      s_axil_arvalid = 1'b0;
      check("mid_en", reg_rd_en, 1);
      check("mid_rvalid", s_axil_rvalid, 1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("mid_rst_rvalid", s_axil_rvalid, 0);
      check("mid_rst_en", reg_rd_en, 0);
      check("mid_rst_arready", s_axil_arready, 1);

      // Read after reset completes normally
      s_axil_rready = 1'b1;
      s_axil_arvalid = 1'b1;
      s_axil_araddr = 32'h44;
      tick();
      s_axil_arvalid = 1'b0;
      check("post_en", reg_rd_en, 1);
      check("post_addr", reg_rd_addr, 32'h44);
      reg_rd_ack = 1'b1;
      reg_rd_data = 32'h0000_55AA;
      tick();
      reg_rd_ack = 1'b0;
      check("post_rvalid", s_axil_rvalid, 1);
      check("post_rdata", s_axil_rdata, 32'h55AA);
      check("post_rresp", s_axil_rresp, 0);
      tick();
      check("post_drained", s_axil_rvalid, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/axil_reg_if_rd_q.md
# axil_reg_if_rd_q

AXI-Lite read-channel-to-register-interface bridge with a queued read-response path, address-range decode and a wait-extendable timeout. It sits between the AXI-Lite interconnect and the block register files of the UDP control plane. Register accesses run back-to-back even while the master stalls `rready`, because completed responses are buffered in an internal FIFO. Out-of-range and timed-out reads return AXI error responses instead of hanging the bus.

## Interface
- `DATA_WIDTH`, 32, data bus width in bits (multiple of 8)
- `ADDR_WIDTH`, 32, AXI address width in bits
- `REG_ADDR_WIDTH`, 16, decoded register window; any `araddr` bit at or above this position set -> DECERR (must be ≤ `ADDR_WIDTH`)
- `TIMEOUT`, 4, register-access timeout in non-wait enable cycles (≥1)
- `RESP_DEPTH`, 4, response FIFO entries (power of 2, ≥2)
- `clk` input 1 — clock
- `rst` input 1 — reset, synchronous, active-high
- `s_axil_araddr` input `ADDR_WIDTH` — read address
- `s_axil_arprot` input 3 — ignored
- `s_axil_arvalid` input 1 — address valid
- `s_axil_arready` output 1 — address ready
- `s_axil_rdata` output `DATA_WIDTH` — read data
- `s_axil_rresp` output 2 — 00 OKAY, 10 SLVERR, 11 DECERR
- `s_axil_rvalid` output 1 — response valid
- `s_axil_rready` input 1 — response ready
- `reg_rd_addr` output `ADDR_WIDTH` — registered access address
- `reg_rd_en` output 1 — access strobe, held until completion
- `reg_rd_data` input `DATA_WIDTH` — register data, sampled on completion
- `reg_rd_wait` input 1 — freezes the timeout counter
- `reg_rd_ack` input 1 — access complete

## Operation
- State machine: IDLE, ACCESS, DECERR.
- IDLE: `arready = (state==IDLE) && (fifo_count < RESP_DEPTH)`, combinational.
- On an AR handshake, `araddr` is captured into `reg_rd_addr` and the timeout counter loads `TIMEOUT-1`.
  - In range -> ACCESS.
  - Out of range -> DECERR.
- ACCESS: `reg_rd_en`=1.
  - Completion when `reg_rd_ack`=1: push {`reg_rd_data`, 00}, go to IDLE.
  - Otherwise, if counter==0 and `!reg_rd_wait`: timeout completion (see Configuration), go to IDLE.
  - Otherwise, if `!reg_rd_wait`: counter decrements.
  - `reg_rd_wait`=1 holds the counter indefinitely.
  - `ack` takes priority over timeout in the same cycle.
- DECERR: no register access (`reg_rd_en`=0). Push {0, 11}, go to IDLE.
- Counter width is `$clog2(TIMEOUT+1)`, so `TIMEOUT`=1 is legal and the counter is never 0 bits wide.
- FIFO:
  - Read and write pointers wrap modulo `RESP_DEPTH`.
  - `fifo_count` holds 0..`RESP_DEPTH`.
  - A push and a pop in the same cycle leave the count unchanged.
  - `rvalid = fifo_count != 0`.
  - `rdata`/`rresp` come from the head entry and are forced to 0 while `rvalid`=0.
- Overflow cannot occur: AR is only accepted when a slot is free, and only one access is ever in flight.
- Responses are returned strictly in AR order.

## Timing
- Reset values:
  - `arready`=1
  - `rvalid`=0
  - `rdata`=0
  - `rresp`=0
  - `reg_rd_en`=0
  - `reg_rd_addr`=0
  - state IDLE, FIFO empty
- Reset mid-access: `reg_rd_en` drops the next cycle. Queued and in-flight responses are discarded with no response issued.
- Latency with AR accepted in cycle N:
  - `reg_rd_en` high from cycle N+1.
  - With `ack` in N+1, `rvalid` rises in N+2 (minimum 2 cycles).
  - DECERR: `rvalid` in N+2.
- Back-to-back: after completion in cycle M, the next AR is accepted in M+1. Throughput is 1 access per 2 cycles with immediate `ack`.
- Timeout with no `wait` and no `ack`: completion in cycle N+`TIMEOUT`. `reg_rd_en` is high for exactly `TIMEOUT` cycles.
- When the FIFO is full, `arready`=0 and stays 0 until the cycle after the first pop.

## Configuration
- `AXIL_REG_RD_TIMEOUT_ERR_EN`
  - Defined: a timeout completion pushes {0, 10} (SLVERR).
  - Undefined: a timeout completion pushes {`reg_rd_data`, 00} (OKAY with whatever data is present).
- DECERR behaviour is identical in both builds.

## Test plan
- Single read: AR addr 0x0000_0010; `ack` asserted in the first `reg_rd_en` cycle with data 0xDEAD_BEEF -> `rvalid` 2 cycles after AR, `rdata` 0xDEAD_BEEF, `rresp` 00.
- Backpressure: `rready`=0, issue 5 reads with immediate `ack` (`RESP_DEPTH`=4) -> 4 accepted, `arready` stays 0. Then `rready`=1 -> 4 in-order responses, 5th AR accepted the cycle after the first pop.
- Timeout, `TIMEOUT`=4, no `ack` -> `reg_rd_en` high exactly 4 cycles.
  - Macro defined: `rresp`=10, `rdata`=0.
  - Macro undefined: `rresp`=00, `rdata`=`reg_rd_data`.
- Wait extension: `reg_rd_wait`=1 for 10 cycles, then `ack` -> no timeout, `rresp`=00, `reg_rd_en` high 11 cycles.
- Decode: AR addr 0x0001_0000 with `REG_ADDR_WIDTH`=16 -> `reg_rd_en` never asserted, `rresp`=11, `rdata`=0, `rvalid` 2 cycles after AR.
- Reset during ACCESS with 2 queued responses -> next cycle `rvalid`=0, `reg_rd_en`=0, `arready`=1. A following read completes normally.
